pu_riscv_divider_radix: RTL
===========================

Name: pu_riscv_divider_radix

Overview:
- Next-generation M-extension divide unit for the execute stage. Parallel to the multiplier; results go to writeback.
- Replaces the fixed radix-2, XLEN-cycle divider with a restoring divider that resolves RADIX_BITS quotient bits per cycle.
- Adds a leading-zero early-out, a one-entry quotient/remainder pairing cache (DIV then REM on the same operands completes in one cycle), and a pipeline flush input.

Parameters:
- XLEN, 64: datapath width; 32 or 64.
- ILEN, 64: instruction bus width.
- RADIX_BITS, 2: quotient bits per iteration; 1, 2 or 4; must divide 32.
- EARLY_OUT, 1: 1 enables the dividend leading-zero skip; 0 always runs full iterations.
- CACHE_EN, 1: 1 enables the quotient/remainder pairing cache.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_stall  in  1  execute stage stalled; no new operation is accepted.
- flush  in  1  kill the in-flight operation (branch/exception).
- div_stall  out  1  divider busy; stalls the pipeline.
- id_bubble  in  1  the issued instruction is invalid.
- id_instr  in  ILEN  issued instruction.
- opA  in  XLEN  dividend.
- opB  in  XLEN  divisor.
- st_xlen  in  2  current XLEN mode; RV32I means word ops are illegal and are ignored.
- div_bubble  out  1  0 means div_r is valid this cycle.
- div_r  out  XLEN  result.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, div_stall=0, div_bubble=1, div_r=0, cache invalid. Reset mid-operation abandons the operation; no result is produced.
- Decode uses the package constants DIV/DIVU/REM/REMU and the W variants (xlen32=0 only). Other instructions are ignored.
- W = 32 for W ops, else XLEN.
- div_bubble defaults to 1 every cycle; it is low for exactly one cycle per result.
- Acceptance happens in IDLE when !ex_stall && !id_bubble && decode hits && !flush. Call the acceptance cycle N.
- Immediate cases: result visible in cycle N+1, div_stall stays 0.
  - Divide by zero: DIV* gives all ones (W ops sign-extended), REM* gives the dividend (W ops sext32).
  - Signed overflow (-2^(W-1) / -1): DIV gives -2^(W-1) sign-extended; REM gives 0.
  - Dividend zero with EARLY_OUT=1: result 0.
  - Cache hit: CACHE_EN=1, cache valid, same opA[W-1:0], opB[W-1:0], signedness and W flag, and the op asks for the other half (quotient vs remainder) of the cached pair. div_r is the cached value with sign correction already applied.
- Otherwise the FSM goes IDLE->DIV and div_stall=1 from cycle N+1.
- Operand setup: a=|dividend|, b=|divisor| for signed ops (W ops sext32 first). neg_q = sign(A)^sign(B); neg_r = sign(A).
- Early-out: lz = leading zeros of a within W bits, and S = floor(lz/RADIX_BITS)*RADIX_BITS. a is pre-shifted left by S. Iterations K = (W-S)/RADIX_BITS. With EARLY_OUT=0, S=0.
- DIV state: per cycle, perform RADIX_BITS restoring steps combinationally (shift, subtract b, restore on borrow, shift in a quotient bit). Counter decrements; at zero go to RES.
- RES state, cycle N+K+1: registers div_r with the sign-corrected quotient/remainder (W ops sext32), div_bubble=0, div_stall=0 in cycle N+K+2.
  - If CACHE_EN, the cache stores {operands, mode, corrected q, corrected r} and is marked valid.
  - Then the FSM returns to IDLE.
- A new operation may be accepted in the same cycle that div_bubble=0 is visible (back-to-back).
- Flush: flush=1 at an edge in DIV or RES goes to IDLE, div_stall=0, div_bubble=1, and no result is produced. flush in IDLE blocks acceptance.
- Cache: invalidated by reset. It is not invalidated by flush, because the cached results are architecturally correct.
- ex_stall is ignored while in DIV/RES; the divider already holds the pipeline.

Test Plan:
- XLEN=64, RADIX_BITS=2, EARLY_OUT=0: DIVU opA=0xFFFF_FFFF_FFFF_FFFF, opB=3 at cycle N. Expect div_stall high N+1..N+33, div_bubble=0 at N+34, div_r=0x5555_5555_5555_5555.
- DIV opA=-7, opB=2 -> div_r=-3. Next cycle REM with the same operands -> div_r=-1 at N+1, no stall (cache hit). A following REMU with the same operands -> full-length operation.
- DIVW opA=0x8000_0000, opB=0xFFFF_FFFF -> div_r=0xFFFF_FFFF_8000_0000 at N+1. REMUW opB=0, opA=0x8000_0001 -> div_r=0xFFFF_FFFF_8000_0001.
- EARLY_OUT=1: DIVU opA=100, opB=7. lz=57, S=56, K=4; expect div_bubble=0 at N+6, div_r=14. REMU gives 2 via the cache.
- Assert flush at N+5 of a 64-bit DIV -> div_stall=0 at N+6, and div_bubble stays 1 for 40 cycles. Assert rst mid-DIV -> all outputs at reset values, and the cache misses on re-issue.
- st_xlen=RV32I with DIVW issued -> ignored (no stall, no result). Sweep RADIX_BITS=1,4 on random operands against a reference model.

Source files
------------

// File: rtl/pu_riscv_divider_radix.sv
// Multi-bit-per-cycle restoring divider for the RISC-V M extension (DIV/DIVU/REM/REMU + W forms).
// Includes a dividend leading-zero skip, a quotient/remainder pairing cache and a pipeline flush.
module pu_riscv_divider_radix #(
    parameter int XLEN       = 64,
    parameter int ILEN       = 64,
    parameter int RADIX_BITS = 2,
    parameter int EARLY_OUT  = 1,
    parameter int CACHE_EN   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            div_stall,
    input  logic            id_bubble,
    input  logic [ILEN-1:0] id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            div_bubble,
    output logic [XLEN-1:0] div_r
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [1:0] RV32I     = 2'b01;
    localparam int         RB_LOG    = $clog2(RADIX_BITS);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RES} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] o;
        o = v;
        for (int i = 32; i < XLEN; i++) o[i] = v[31];
        return o;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] o;
        o = v;
        for (int i = 32; i < XLEN; i++) o[i] = 1'b0;
        return o;
    endfunction

    state_t          state_q, state_d;
    logic            bubble_q;
    logic [XLEN-1:0] div_r_q;
    logic [XLEN-1:0] a_q, r_q, q_q, b_q, key_a_q, key_b_q;
    logic [7:0]      cnt_q;
    logic            neg_q_q, neg_r_q, rem_q, word_q, sgn_q;
    logic            cache_vld_q, cache_sgn_q, cache_word_q, cache_rem_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_q_q, cache_r_q;

    logic            is_word, is_sgn, is_rem, dec_hit, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_al, key_a, key_b, min_val;
    logic            sign_a, sign_b, ovf, cache_hit, imm_hit, lz_found;
    logic [XLEN-1:0] imm_res, q_fix, r_fix;
    logic [7:0]      lz, s_amt, w_bits, iters;

    // Decode: word forms exist only on a 64-bit datapath outside RV32I mode
    assign is_word = (id_instr[6:0] == OPC_OP32);
    assign is_sgn  = ~id_instr[12];
    assign is_rem  = id_instr[13];
    assign dec_hit = (id_instr[31:25] == F7_MULDIV) && id_instr[14] &&
                     ((id_instr[6:0] == OPC_OP) ||
                      (is_word && (XLEN > 32) && (st_xlen != RV32I)));
    assign accept  = (state_q == S_IDLE) && !ex_stall && !id_bubble && dec_hit && !flush;

    assign a_ext   = is_word ? sext32(opA) : opA;
    assign b_ext   = is_word ? sext32(opB) : opB;
    assign sign_a  = is_sgn & a_ext[XLEN-1];
    assign sign_b  = is_sgn & b_ext[XLEN-1];
    assign a_abs   = is_word ? zext32(sign_a ? -a_ext : a_ext) : (sign_a ? -a_ext : a_ext);
    assign b_abs   = is_word ? zext32(sign_b ? -b_ext : b_ext) : (sign_b ? -b_ext : b_ext);
    assign a_al    = is_word ? (a_abs << (XLEN-32)) : a_abs;
    assign key_a   = is_word ? zext32(opA) : opA;
    assign key_b   = is_word ? zext32(opB) : opB;
    assign min_val = is_word ? sext32(XLEN'(32'h8000_0000)) : (XLEN'(1) << (XLEN-1));
    assign ovf     = is_sgn && (a_ext == min_val) && (b_ext == '1);

    assign cache_hit = (CACHE_EN != 0) && cache_vld_q && (cache_a_q == key_a) &&
                       (cache_b_q == key_b) && (cache_sgn_q == is_sgn) &&
                       (cache_word_q == is_word) && (cache_rem_q != is_rem);

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = XLEN-1; i >= 0; i--) begin
            if (!lz_found) begin
                if (a_al[i]) lz_found = 1'b1;
                else         lz = lz + 8'd1;
            end
        end
    end

    assign s_amt  = (EARLY_OUT != 0) ? ((lz >> RB_LOG) << RB_LOG) : 8'd0;
    assign w_bits = is_word ? 8'd32 : 8'(XLEN);
    assign iters  = (w_bits - s_amt) >> RB_LOG;

    always_comb begin
        imm_hit = 1'b1;
        imm_res = '0;
        if (b_ext == '0)                          imm_res = is_rem ? a_ext : '1;
        else if (ovf)                             imm_res = is_rem ? '0 : a_ext;
        else if ((EARLY_OUT != 0) && a_ext == '0) imm_res = '0;
        else if (cache_hit)                       imm_res = is_rem ? cache_r_q : cache_q_q;
        else                                      imm_hit = 1'b0;
    end

    // One restoring step per stage; the dividend MSB is always at XLEN-1
    logic [XLEN-1:0] st_a [RADIX_BITS+1];
    logic [XLEN-1:0] st_r [RADIX_BITS+1];
    logic [XLEN-1:0] st_q [RADIX_BITS+1];
    assign st_a[0] = a_q;
    assign st_r[0] = r_q;
    assign st_q[0] = q_q;
    genvar gi;
    generate
        for (gi = 0; gi < RADIX_BITS; gi++) begin : g_step
            logic [XLEN:0] sh_r, diff;
            assign sh_r         = {st_r[gi], st_a[gi][XLEN-1]};
            assign diff         = sh_r - {1'b0, b_q};
            assign st_r[gi+1]   = diff[XLEN] ? sh_r[XLEN-1:0] : diff[XLEN-1:0];
            assign st_a[gi+1]   = {st_a[gi][XLEN-2:0], 1'b0};
            assign st_q[gi+1]   = {st_q[gi][XLEN-2:0], ~diff[XLEN]};
        end
    endgenerate

    assign q_fix = word_q ? sext32(neg_q_q ? -q_q : q_q) : (neg_q_q ? -q_q : q_q);
    assign r_fix = word_q ? sext32(neg_r_q ? -r_q : r_q) : (neg_r_q ? -r_q : r_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !imm_hit) state_d = S_DIV;
            S_DIV:   if (flush) state_d = S_IDLE;
                     else if (cnt_q == 8'd0) state_d = S_RES;
            S_RES:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_stall = (state_q != S_IDLE);
    end

    assign div_bubble = bubble_q;
    assign div_r      = div_r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q    <= 1'b1;
            div_r_q     <= '0;
            cache_vld_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            bubble_q <= 1'b1;
            case (state_q)
                S_IDLE: if (accept) begin
                    if (imm_hit) begin
                        bubble_q <= 1'b0;
                        div_r_q  <= imm_res;
                    end else begin
                        a_q     <= a_al << s_amt;
                        b_q     <= b_abs;
                        r_q     <= '0;
                        q_q     <= '0;
                        cnt_q   <= iters - 8'd1;
                        neg_q_q <= sign_a ^ sign_b;
                        neg_r_q <= sign_a;
                        rem_q   <= is_rem;
                        word_q  <= is_word;
                        sgn_q   <= is_sgn;
                        key_a_q <= key_a;
                        key_b_q <= key_b;
                    end
                end
                S_DIV: begin
                    a_q   <= st_a[RADIX_BITS];
                    r_q   <= st_r[RADIX_BITS];
                    q_q   <= st_q[RADIX_BITS];
                    cnt_q <= cnt_q - 8'd1;
                end
                S_RES: if (!flush) begin
                    bubble_q     <= 1'b0;
                    div_r_q      <= rem_q ? r_fix : q_fix;
                    cache_vld_q  <= (CACHE_EN != 0);
                    cache_a_q    <= key_a_q;
                    cache_b_q    <= key_b_q;
                    cache_sgn_q  <= sgn_q;
                    cache_word_q <= word_q;
                    cache_rem_q  <= rem_q;
                    cache_q_q    <= q_fix;
                    cache_r_q    <= r_fix;
                end
                default: ;
            endcase
        end
    end

    logic unused_instr;
    generate
        if (ILEN > 32) begin : g_wide
            assign unused_instr = ^{id_instr[ILEN-1:32], id_instr[24:15], id_instr[11:7]};
        end else begin : g_narrow
            assign unused_instr = ^{id_instr[24:15], id_instr[11:7]};
        end
    endgenerate
endmodule
